// File: rtl/serdes_rx_pkg.sv
// Shared constants for the SERDES receive frame parser: FSM state encoding,
// error codes, default frame header and a saturating counter helper.
package serdes_rx_pkg;

    // Parser state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CSUM    = 2'd3;

    // Error codes reported on O_err_code
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_LEN   = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    // Default frame header word
    localparam logic [15:0] HDR_DEFAULT = 16'hA55A;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/serdes_rx_frame_parser_if.sv
// Link-side and payload-side signal bundle of the frame parser.
// master = link/test driver side, slave = parser side.
interface serdes_rx_frame_parser_if;

    logic [15:0] user_data;
    logic        data_ena;
    logic        rx_link;
    logic [15:0] pl_data;
    logic        pl_valid;
    logic        pl_sof;
    logic        pl_eof;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    modport master (
        output user_data, data_ena, rx_link,
        input  pl_data, pl_valid, pl_sof, pl_eof,
        input  frame_ok, frame_err, err_code, frame_cnt, err_cnt
    );

    modport slave (
        input  user_data, data_ena, rx_link,
        output pl_data, pl_valid, pl_sof, pl_eof,
        output frame_ok, frame_err, err_code, frame_cnt, err_cnt
    );

endinterface

// File: rtl/serdes_rx_csum16.sv
// 16-bit modulo-2^16 checksum accumulator: clear, seed (load) or add.
module serdes_rx_csum16 (
    input  logic        I_serdes_rx_clk,
    input  logic        I_rst_n,
    input  logic        I_clear,
    input  logic        I_seed,
    input  logic        I_add_en,
    input  logic [15:0] I_data,
    output logic [15:0] O_sum
);

    logic [15:0] sum_q;
    logic [15:0] sum_d;

    // Next accumulator value; clear beats seed beats add
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        sum_d = sum_q;
        if (I_clear) begin
            sum_d = '0;
        end else if (I_seed) begin
            sum_d = I_data;
        end else if (I_add_en) begin
            sum_d = sum_q + I_data;  // carry out is intentionally dropped
        end
    end

    // Accumulator register
    always_ff @(posedge I_serdes_rx_clk or negedge I_rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!I_rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign O_sum = sum_q;

endmodule

// File: rtl/serdes_rx_frame_parser.sv
// Receive frame parser: HDR, LEN, L payload words, CSUM. Streams payload with
// sof/eof, pulses ok/err per frame, and aborts on idle timeout or link loss.
module serdes_rx_frame_parser
    import serdes_rx_pkg::*;
#(
    parameter logic [15:0] P_HDR     = HDR_DEFAULT,
    parameter int          P_MAX_LEN = 256,
    parameter int          P_TIMEOUT = 1023
) (
    input  logic        I_serdes_rx_clk,
    input  logic        I_rst_n,
    input  logic [15:0] I_user_data,
    input  logic        I_data_ena,
    input  logic        I_rx_link,
    output logic [15:0] O_pl_data,
    output logic        O_pl_valid,
    output logic        O_pl_sof,
    output logic        O_pl_eof,
    output logic        O_frame_ok,
    output logic        O_frame_err,
    output logic [1:0]  O_err_code,
    output logic [15:0] O_frame_cnt,
    output logic [15:0] O_err_cnt
);

    localparam int REM_W = $clog2(P_MAX_LEN) + 1;
    localparam int TO_W  = $clog2(P_TIMEOUT + 1);
    // Gap count seen on the cycle that completes P_TIMEOUT consecutive gaps
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(P_TIMEOUT - 1);

    logic [1:0]       state_q,     state_d;
    logic [REM_W-1:0] rem_q,       rem_d;
    logic [TO_W-1:0]  gap_q,       gap_d;
    logic             first_q,     first_d;
    logic [15:0]      pl_data_q,   pl_data_d;
    logic             pl_valid_q,  pl_valid_d;
    logic             pl_sof_q,    pl_sof_d;
    logic             pl_eof_q,    pl_eof_d;
    logic             frame_ok_q,  frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q,  err_code_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      err_cnt_q,   err_cnt_d;

    logic        csum_clear, csum_seed, csum_add;
    logic [15:0] csum_sum;
    logic        in_frame, abort, len_ok;

    serdes_rx_csum16 u_csum (
        .I_serdes_rx_clk (I_serdes_rx_clk),
        .I_rst_n         (I_rst_n),
        .I_clear         (csum_clear),
        .I_seed          (csum_seed),
        .I_add_en        (csum_add),
        .I_data          (I_user_data),
        .O_sum           (csum_sum)
    );

    // Frame FSM, payload staging, response pulses and counters
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        first_d     = first_q;
        pl_data_d   = pl_data_q;
        pl_valid_d  = 1'b0;
        pl_sof_d    = 1'b0;
        pl_eof_d    = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        csum_clear  = 1'b0;
        csum_seed   = 1'b0;
        csum_add    = 1'b0;

        in_frame = (state_q != ST_IDLE);
        len_ok   = (I_user_data != 16'd0) && (32'(I_user_data) <= 32'(P_MAX_LEN));
        // Timeout and link loss share one abort path, so a coincidence gives one pulse
        abort    = in_frame && (!I_rx_link || (!I_data_ena && gap_q == TO_LAST));
        gap_d    = (in_frame && !I_data_ena) ? gap_q + TO_W'(1) : '0;

        if (abort) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_ABORT;
            csum_clear  = 1'b1;
            gap_d       = '0;
        end else if (I_data_ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (I_rx_link && I_user_data == P_HDR) begin
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    csum_seed = 1'b1;
                    rem_d     = I_user_data[REM_W-1:0];
                    first_d   = 1'b1;
                    if (len_ok) begin
                        state_d = ST_PAYLOAD;
                    end else begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end
                end
                ST_PAYLOAD: begin
                    csum_add   = 1'b1;
                    pl_valid_d = 1'b1;
                    pl_data_d  = I_user_data;
                    pl_sof_d   = first_q;
                    pl_eof_d   = (rem_q == REM_W'(1));
                    first_d    = 1'b0;
                    rem_d      = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (I_user_data == csum_sum) begin
                        frame_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        frame_cnt_d = frame_ok_d  ? sat_inc16(frame_cnt_q) : frame_cnt_q;
        err_cnt_d   = frame_err_d ? sat_inc16(err_cnt_q)   : err_cnt_q;
    end

    // State and output registers; reset drops any partial frame silently
    always_ff @(posedge I_serdes_rx_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            gap_q       <= '0;
            first_q     <= 1'b0;
            pl_data_q   <= '0;
            pl_valid_q  <= 1'b0;
            pl_sof_q    <= 1'b0;
            pl_eof_q    <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            gap_q       <= gap_d;
            first_q     <= first_d;
            pl_data_q   <= pl_data_d;
            pl_valid_q  <= pl_valid_d;
            pl_sof_q    <= pl_sof_d;
            pl_eof_q    <= pl_eof_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign O_pl_data   = pl_data_q;
    assign O_pl_valid  = pl_valid_q;
    assign O_pl_sof    = pl_sof_q;
    assign O_pl_eof    = pl_eof_q;
    assign O_frame_ok  = frame_ok_q;
    assign O_frame_err = frame_err_q;
    assign O_err_code  = err_code_q;
    assign O_frame_cnt = frame_cnt_q;
    assign O_err_cnt   = err_cnt_q;

endmodule
